// File: rtl/multiplier_iter_nbit.sv
// Iterative unsigned WIDTH x WIDTH shift-add multiplier, one partial product per cycle; latency WIDTH+1
// (or MSB(in1)+2 with EARLY_EXIT). in_rdy only in IDLE; prod/out_val held in DONE until out_rdy.
module multiplier_iter_nbit #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [WIDTH-1:0]   in0,
  input  logic [WIDTH-1:0]   in1,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_a;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_prod;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]   r_cnt;

  logic [PW-1:0]   w_acc_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_calc_last;

  assign w_in_fire  = in_val && in_rdy;
  assign w_out_fire = out_val && out_rdy;
  assign w_acc_nxt  = r_acc + (r_b[0] ? r_a : {PW{1'b0}});
  assign w_b_nxt    = r_b >> 1;

  // Early exit once no multiplier bits remain; the last iteration still folds in r_b[0].
  assign w_calc_last = (r_cnt == LAST_CNT) || (EARLY_EXIT && (w_b_nxt == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_in_fire)   w_state_nxt = CALC;
      CALC:    if (w_calc_last) w_state_nxt = DONE;
      DONE:    if (w_out_fire)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_rdy  = 1'b0;
    out_val = 1'b0;
    busy    = 1'b1;
    case (r_state)
      IDLE: begin
        in_rdy = 1'b1;
        busy   = 1'b0;
      end
      DONE:    out_val = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_prod <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_fire) begin
            r_a   <= {{WIDTH{1'b0}}, in0};
            r_b   <= in1;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        CALC: begin
          r_acc <= w_acc_nxt;
          r_a   <= r_a << 1;
          r_b   <= w_b_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_calc_last) begin
            r_prod <= w_acc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign prod = r_prod;

endmodule
